ram32_8_ctrl: RTL and testbench

Request-side access controller for the 32×8 word RAM. It accepts single-word write, burst-fill and burst-read commands over a valid/ready request channel and drives the RAM's `addr`, `data_in` and `write_en` pins. Read words come back on a valid/ready response channel with backpressure. It sits between the CPU datapath (or a debug/loader agent) and the RAM, so the RAM itself never sees handshake logic.

---
 rtl/ram32_8_ctrl.sv | 156 +++++++++++++++
 tb/tb_ram32_8_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32_8_ctrl.sv
// Request-side access controller for the 32x8 word RAM: single writes, burst
// fills and burst reads, with read words returned on a backpressured channel.
module ram32_8_ctrl #(
  parameter int WORDSIZE  = 8,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_len,
  input  logic [WORDSIZE-1:0]  req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORDSIZE-1:0]  rsp_data,
  output logic                 rsp_last,
  output logic                 busy,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORDSIZE-1:0]  ram_data_in,
  output logic                 ram_write_en,
  input  logic [WORDSIZE-1:0]  ram_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_READ} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  localparam logic [ADDR_SIZE:0]   CNT_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_SIZE:0]    cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]  ram_addr_q, ram_addr_d;
  logic [WORDSIZE-1:0]   ram_data_in_q, ram_data_in_d;
  logic                  ram_write_en_q, ram_write_en_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WORDSIZE-1:0]   rsp_data_q, rsp_data_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  load;
  logic                  rsp_fire;

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = !req_ready;
  assign ram_addr     = ram_addr_q;
  assign ram_data_in  = ram_data_in_q;
  assign ram_write_en = ram_write_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_last     = rsp_last_q;

  // A word is pulled from the RAM whenever the output slot is empty or being drained.
  assign load     = (state_q == S_READ) && (!rsp_valid_q || rsp_ready) && (cnt_q != '0);
  assign rsp_fire = rsp_valid_q && rsp_ready;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value so no path leaves it unassigned (no latch).
    state_d        = state_q;
    cnt_d          = cnt_q;
    ram_addr_d     = ram_addr_q;
    ram_data_in_d  = ram_data_in_q;
    ram_write_en_d = ram_write_en_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_last_d     = rsp_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          unique case (req_op)
            OP_READ: begin
              ram_addr_d = req_addr;
              cnt_d      = {1'b0, req_len} + CNT_ONE;
              state_d    = S_READ;
            end
            OP_WRITE: begin
              ram_addr_d     = req_addr;
              ram_data_in_d  = req_wdata;
              ram_write_en_d = 1'b1;
              state_d        = S_WRITE;
            end
            OP_FILL: begin
              ram_addr_d     = req_addr;
              ram_data_in_d  = req_wdata;
              ram_write_en_d = 1'b1;
              cnt_d          = {1'b0, req_len} + CNT_ONE;
              state_d        = S_FILL;
            end
            default: ;  // reserved op is consumed with no effect
          endcase
        end
      end

      S_WRITE: begin
        ram_write_en_d = 1'b0;
        state_d        = S_IDLE;
      end

      S_FILL: begin
        if (cnt_q == CNT_ONE) begin
          ram_write_en_d = 1'b0;
          cnt_d          = '0;
          state_d        = S_IDLE;
        end else begin
          cnt_d      = cnt_q - CNT_ONE;
          ram_addr_d = ram_addr_q + ADDR_ONE;
        end
      end

      S_READ: begin
        if (load) begin
          rsp_data_d  = ram_data_out;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (cnt_q == CNT_ONE);
          ram_addr_d  = ram_addr_q + ADDR_ONE;
          cnt_d       = cnt_q - CNT_ONE;
        end else if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
        end
        if (rsp_fire && rsp_last_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      ram_addr_q     <= '0;
      ram_data_in_q  <= '0;
      ram_write_en_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_last_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ram_addr_q     <= ram_addr_d;
      ram_data_in_q  <= ram_data_in_d;
      ram_write_en_q <= ram_write_en_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_last_q     <= rsp_last_d;
    end
  end

endmodule

// File: tb/tb_ram32_8_ctrl.sv
// Bench for ram32_8_ctrl: a behavioural 32x8 RAM on the ram_* pins plus an
// expected-memory model updated per request from plain address arithmetic.
module tb_ram32_8_ctrl;

  localparam int W     = 8;
  localparam int A     = 5;
  localparam int DEPTH = 32;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [A-1:0] req_addr;
  logic [A-1:0] req_len;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_last;
  logic         busy;
  logic [A-1:0] ram_addr;
  logic [W-1:0] ram_data_in;
  logic         ram_write_en;
  logic [W-1:0] ram_data_out;

  // Behavioural RAM with a backdoor preload port used only while the DUT is quiet.
  logic [W-1:0] mem [DEPTH];
  logic         pre_we;
  logic [A-1:0] pre_addr;
  logic [W-1:0] pre_data;

  logic [W-1:0] exp_mem [DEPTH];
  int total;
  int bad;
  int last_cycles;

  ram32_8_ctrl #(.WORDSIZE(W), .ADDR_SIZE(A)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data_out = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_data_in;
    else if (pre_we)  mem[pre_addr] <= pre_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit invert);
    for (int i = 0; i < DEPTH; i++) begin
      pre_we   = 1'b1;
      pre_addr = i[A-1:0];
      pre_data = invert ? (i[W-1:0] ^ 8'hFF) : 8'($urandom);
      exp_mem[i] = pre_data;
      step();
    end
    pre_we = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [A-1:0] addr,
                      input logic [A-1:0] len, input logic [W-1:0] wd);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: req_ready=%b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [A-1:0] addr, input logic [W-1:0] wd);
    send(OP_WRITE, addr, 5'd0, wd);
    total++;
    if (ram_write_en !== 1'b1 || ram_addr !== addr || ram_data_in !== wd || busy !== 1'b1) begin
      bad++;
      $display("FAIL write_issue: we=%b addr=%0d din=%h busy=%b want 1 %0d %h 1",
               ram_write_en, ram_addr, ram_data_in, busy, addr, wd);
    end
    step();
    exp_mem[addr] = wd;
    total++;
    if (ram_write_en !== 1'b0 || req_ready !== 1'b1 || mem[addr] !== wd) begin
      bad++;
      $display("FAIL write_done: we=%b ready=%b mem=%h want 0 1 %h",
               ram_write_en, req_ready, mem[addr], wd);
    end
  endtask

  task automatic do_fill(input logic [A-1:0] addr, input logic [A-1:0] len, input logic [W-1:0] wd);
    int k;
    int exp_a;
    k = 0;
    send(OP_FILL, addr, len, wd);
    while (ram_write_en === 1'b1 && k < 40) begin
      exp_a = (int'(addr) + k) % DEPTH;
      total++;
      if (int'(ram_addr) != exp_a || ram_data_in !== wd) begin
        bad++;
        $display("FAIL fill_word: addr=%0d din=%h want %0d %h", ram_addr, ram_data_in, exp_a, wd);
      end
      exp_mem[exp_a] = wd;
      k++;
      step();
    end
    total++;
    if (k != int'(len) + 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fill_count: writes=%0d busy=%b want %0d 0", k, busy, int'(len) + 1);
    end
  endtask

  task automatic do_read(input logic [A-1:0] addr, input logic [A-1:0] len,
                         input int pct, input int inject);
    int n;
    int got;
    int cyc;
    int budget;
    bit stalled;
    logic [W-1:0] held_d;
    logic held_l;
    logic [W-1:0] exp_d;
    logic exp_l;
    n = int'(len) + 1;
    got = 0;
    cyc = 0;
    budget = 6 * n + 40;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    send(OP_READ, addr, len, 8'h00);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_latency: rsp_valid=%b want 0 one cycle after accept", rsp_valid);
    end
    while (got < n && cyc < budget) begin
      if (stalled) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== held_d || rsp_last !== held_l) begin
          bad++;
          $display("FAIL read_hold: valid=%b data=%h last=%b want 1 %h %b",
                   rsp_valid, rsp_data, rsp_last, held_d, held_l);
        end
      end
      total++;
      if (ram_write_en !== 1'b0) begin
        bad++;
        $display("FAIL read_no_we: ram_write_en=%b want 0", ram_write_en);
      end
      rsp_ready = ($urandom_range(99) < pct);
      if (cyc == inject) begin
        req_valid = 1'b1;
        req_op    = OP_WRITE;
        req_addr  = 5'd5;
        req_wdata = 8'h11;
        total++;
        if (req_ready !== 1'b0) begin
          bad++;
          $display("FAIL busy_ready: req_ready=%b want 0", req_ready);
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        exp_d = exp_mem[(int'(addr) + got) % DEPTH];
        exp_l = (got == n - 1);
        total++;
        if (rsp_data !== exp_d || rsp_last !== exp_l) begin
          bad++;
          $display("FAIL read_word%0d: data=%h last=%b want %h %b", got, rsp_data, rsp_last, exp_d, exp_l);
        end
        got++;
      end
      stalled = (rsp_valid === 1'b1) && !rsp_ready;
      held_d  = rsp_data;
      held_l  = rsp_last;
      step();
      cyc++;
      req_valid = 1'b0;
    end
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL read_timeout: got %0d words want %0d", got, n);
    end
    last_cycles = cyc;
    rsp_ready = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL read_tail: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || ram_addr !== '0 || ram_data_in !== '0 ||
        ram_write_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b busy=%b addr=%0d din=%h we=%b rv=%b rd=%h rl=%b want 1 0 0 0 0 0 0 0",
               req_ready, busy, ram_addr, ram_data_in, ram_write_en, rsp_valid, rsp_data, rsp_last);
    end
    preload(1'b0);
    rst = 1'b0;
    step();
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd3, 8'h5A);
    do_read(5'd3, 5'd0, 100, -1);
  endtask

  task automatic test_back_to_back();
    do_write(5'd10, 8'($urandom));
    do_write(5'd11, 8'($urandom));
    do_read(5'd10, 5'd1, 100, -1);
  endtask

  task automatic test_fill();
    do_fill(5'd30, 5'd3, 8'hC3);
    do_read(5'd0, 5'd31, 100, -1);
    total++;
    if (last_cycles != 33) begin
      bad++;
      $display("FAIL read_throughput: cycles=%0d want 33", last_cycles);
    end
  endtask

  task automatic test_read_backpressure();
    preload(1'b1);
    do_read(5'd28, 5'd7, 50, -1);
  endtask

  task automatic test_busy_ignore();
    do_read(5'd0, 5'd15, 70, 4);
    do_read(5'd5, 5'd0, 100, -1);
  endtask

  task automatic test_reset_mid_fill();
    preload(1'b0);
    send(OP_FILL, 5'd0, 5'd31, 8'h77);
    repeat (10) step();
    for (int i = 0; i < 10; i++) exp_mem[i] = 8'h77;
    #1 rst = 1'b1;
    #1;
    total++;
    if (ram_write_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || ram_addr !== '0) begin
      bad++;
      $display("FAIL reset_mid_fill: we=%b busy=%b rv=%b addr=%0d want 0 0 0 0",
               ram_write_en, busy, rsp_valid, ram_addr);
    end
    #1 rst = 1'b0;
    step();
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_ready: req_ready=%b want 1", req_ready);
    end
    do_read(5'd0, 5'd31, 100, -1);
  endtask

  task automatic test_reserved();
    send(OP_RSVD, 5'd7, 5'd3, 8'hAA);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || ram_write_en !== 1'b0 || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL reserved_op%0d: ready=%b busy=%b we=%b rv=%b want 1 0 0 0",
                 i, req_ready, busy, ram_write_en, rsp_valid);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++) begin
      logic [1:0]   op;
      logic [A-1:0] a;
      logic [A-1:0] l;
      op = 2'($urandom_range(2));
      a  = 5'($urandom);
      l  = 5'($urandom);
      case (op)
        OP_WRITE: do_write(a, 8'($urandom));
        OP_FILL:  do_fill(a, l, 8'($urandom));
        default:  do_read(a, l, int'($urandom_range(100, 30)), -1);
      endcase
    end
    do_read(5'd0, 5'd31, 60, -1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    last_cycles = 0;
    req_valid = 1'b0;
    req_op = '0;
    req_addr = '0;
    req_len = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_fill();
    test_read_backpressure();
    test_busy_ignore();
    test_reset_mid_fill();
    test_reserved();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
